i2c_master_addr_tx: RTL and testbench



---
 rtl/i2c_pkg.sv | 15 +
 rtl/scl_quarter_timer.sv | 56 +++++
 rtl/i2c_master_addr_tx.sv | 112 +++++++++++
 tb/tb_i2c_master_addr_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master address-phase transmitter.
package i2c_pkg;
  localparam int I2C_ADDR_W    = 7;
  localparam int I2C_ADDR_BITS = 8;  // address plus R/W
  localparam int I2C_QUARTERS  = 4;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_BIT,
    M_ACK,
    M_PARK,
    M_STOP
  } maddr_state_e;
endpackage

// File: rtl/scl_quarter_timer.sv
// SCL quarter-period timebase: qcnt wraps every CLK_DIV cycles, phase walks q0..q3.
// With SCL_STRETCH_EN defined, q2 start holds until the synchronized SCL reads high.
module scl_quarter_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       FPGA_clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_clr,
  input  logic       i_stretch,
  input  logic       i_scl,
  output logic       o_qtick,
  output logic [1:0] o_phase
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_phase;
  logic          w_hold;

`ifdef SCL_STRETCH_EN
  logic [1:0] r_sync;
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_scl};
  end
  // A slave may keep SCL low after we release it; wait for it to actually rise.
  assign w_hold = i_stretch && (r_phase == 2'd2) && (r_qcnt == '0) && !r_sync[1];
`else
  logic w_unused_scl;
  assign w_unused_scl = i_scl ^ i_stretch;
  assign w_hold       = 1'b0;
`endif

  assign o_qtick = i_run && !w_hold && (r_qcnt == QW'(CLK_DIV - 1));
  assign o_phase = r_phase;

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      r_qcnt  <= '0;
      r_phase <= '0;
    end else if (!i_run) begin
      r_qcnt  <= '0;
      r_phase <= '0;
    end else if (!w_hold) begin
      if (o_qtick) begin
        r_qcnt  <= '0;
        r_phase <= (i_clr || r_phase == 2'(I2C_QUARTERS - 1)) ? 2'd0 : r_phase + 2'd1;
      end else begin
        r_qcnt <= r_qcnt + QW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_master_addr_tx.sv
// I2C master address phase: START, 8 bits MSB-first, ACK sample, then PARK or STOP.
// Optional macro SCL_STRETCH_EN enables slave clock stretching via SCL_in.
module i2c_master_addr_tx
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  FPGA_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [I2C_ADDR_W-1:0] I2C_addr,
  input  logic                  rw,
  input  logic                  stop_req,
  input  logic                  SDA_in,
  input  logic                  SCL_in,
  output logic                  SCL_oe,
  output logic                  SDA_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  acked
);
  maddr_state_e             r_state, w_next;
  logic [I2C_ADDR_BITS-1:0] r_shreg;
  logic [3:0]               r_bitcnt;
  logic                     r_acked, r_done;
  logic                     w_qtick, w_clr, w_run, w_stretch, w_qend;
  logic [1:0]               w_phase;

  assign w_run     = (r_state == M_START) || (r_state == M_BIT) ||
                     (r_state == M_ACK)   || (r_state == M_STOP);
  assign w_stretch = (r_state == M_BIT) || (r_state == M_ACK) || (r_state == M_STOP);
  assign w_qend    = w_qtick && (w_phase == 2'd3);

  scl_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .FPGA_clk  (FPGA_clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_clr     (w_clr),
    .i_stretch (w_stretch),
    .i_scl     (SCL_in),
    .o_qtick   (w_qtick),
    .o_phase   (w_phase)
  );

  assign busy  = (r_state != M_IDLE);
  assign done  = r_done;
  assign acked = r_acked;

  always_comb begin
    w_next = r_state;
    SCL_oe = 1'b0;
    SDA_oe = 1'b0;
    w_clr  = 1'b0;
    unique case (r_state)
      M_IDLE:  if (enable) w_next = M_START;
      M_START: begin
        SDA_oe = 1'b1;
        // START is only two quarters; realign the phase so BIT begins at q0
        if (w_qtick && w_phase == 2'd1) begin
          w_clr  = 1'b1;
          w_next = M_BIT;
        end
      end
      M_BIT: begin
        SCL_oe = (w_phase < 2'd2);
        SDA_oe = ~r_shreg[I2C_ADDR_BITS-1];
        if (w_qend && r_bitcnt == 4'(I2C_ADDR_BITS - 1)) w_next = M_ACK;
      end
      M_ACK: begin
        SCL_oe = (w_phase < 2'd2);
        if (w_qend) w_next = r_acked ? M_PARK : M_STOP;
      end
      M_PARK: begin
        SCL_oe = 1'b1;
        if (stop_req) w_next = M_STOP;
      end
      M_STOP: begin
        SCL_oe = (w_phase < 2'd2);
        SDA_oe = (w_phase != 2'd3);
        if (w_qend) w_next = M_IDLE;
      end
      default: w_next = M_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      r_state  <= M_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_acked  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == M_ACK) && w_qend;
      case (r_state)
        M_IDLE: if (enable) begin
          r_shreg  <= {I2C_addr, rw};
          r_bitcnt <= '0;
          r_acked  <= 1'b0;
        end
        M_BIT: if (w_qend) begin
          r_shreg  <= {r_shreg[I2C_ADDR_BITS-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        // sample at the end of q2, while SCL is high
        M_ACK: if (w_qtick && w_phase == 2'd2) r_acked <= ~SDA_in;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_addr_tx.sv
// Randomized bench for i2c_master_addr_tx with a wired-AND bus and a simple slave model.
module tb_i2c_master_addr_tx;
  localparam int D = 4;
`ifdef SCL_STRETCH_EN
  localparam int PEN = 2;  // synchronizer delay on every SCL release
`else
  localparam int PEN = 0;
`endif

  logic       FPGA_clk = 1'b0, rst = 1'b1, enable = 1'b0, rw = 1'b0, stop_req = 1'b0;
  logic [6:0] I2C_addr = '0;
  logic       SCL_oe, SDA_oe, busy, done, acked;
  logic       slv_pull = 1'b0;
  int         hold_cnt = 0;
  wire        sda_bus = ~SDA_oe & ~slv_pull;
  wire        scl_bus = ~SCL_oe & ~(hold_cnt != 0);

  i2c_master_addr_tx #(.CLK_DIV(D)) dut (
    .FPGA_clk (FPGA_clk), .rst (rst), .enable (enable), .I2C_addr (I2C_addr),
    .rw (rw), .stop_req (stop_req), .SDA_in (sda_bus), .SCL_in (scl_bus),
    .SCL_oe (SCL_oe), .SDA_oe (SDA_oe), .busy (busy), .done (done), .acked (acked)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // bus observer and slave: ACK by holding SDA through the 9th SCL low/high,
  // optional clock stretch starting at bit 3
  logic mon_en = 1'b0, ack_slave = 1'b0, stretch = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
  bit   rises[$];
  int   falls = 0, starts = 0, stops = 0;
  always @(negedge FPGA_clk) begin
    if (hold_cnt > 0) hold_cnt--;
    if (mon_en) begin
      if (p_scl && !scl_bus) begin
        falls++;
        if (stretch && falls == 4) hold_cnt = 2 * D + 20;
      end
      if (!p_scl && scl_bus) rises.push_back(sda_bus);
      if (p_scl && scl_bus && p_sda && !sda_bus) starts++;
      if (p_scl && scl_bus && !p_sda && sda_bus) stops++;
      slv_pull = ack_slave && (falls == 9);
    end else begin
      slv_pull = 1'b0;
    end
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  task automatic run_xfer(input logic [6:0] a, input logic r, input logic ackp,
                          input logic str, input logic hold_en);
    logic [7:0] b;
    int n, lat, exp_lat;
    b = {a, r};
    chk("idle_busy", busy, 1'b0);
    rises.delete();
    falls = 0; starts = 0; stops = 0;
    ack_slave = ackp; stretch = str; mon_en = 1'b1;
    I2C_addr = a; rw = r; enable = 1'b1;
    @(posedge FPGA_clk); #2;
    if (!hold_en) enable = 1'b0;
    I2C_addr = 7'($urandom); rw = 1'($urandom);
    n = 0;
    do begin @(posedge FPGA_clk); #1; n++; end while (!done && n < 600);
    chk("done_seen", done, 1'b1);
    lat     = n + 1;
    exp_lat = 1 + 38 * D + 9 * PEN;
    if (str) begin
`ifdef SCL_STRETCH_EN
      chk("stretch_lat", (lat - exp_lat >= 20) && (lat - exp_lat <= 22), 1'b1);
`else
      chk("stretch_ignored_lat", lat, exp_lat);
`endif
    end else begin
      chk("done_lat", lat, exp_lat);
    end
    chk("acked", acked, ackp);
    chk("start_cond", starts, 1);
`ifndef SCL_STRETCH_EN
    if (!str) begin
`else
    begin
`endif
      chk("n_rises", rises.size(), 9);
      for (int i = 0; i < 8; i++)
        if (rises.size() > i) chk("addr_bit", rises[i], b[7-i]);
      if (rises.size() > 8) chk("ack_bit", rises[8], !ackp);
    end
    if (hold_en) enable = 1'b0;
    if (ackp) begin
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
        if (hold_en) enable = 1'b1;
        @(posedge FPGA_clk); #1;
        if (w == 0) chk("done_pulse", done, 1'b0);
        chk("park_out", {SCL_oe, SDA_oe, busy}, 3'b101);
      end
      enable = 1'($urandom);  // STOP must win over enable
      stop_req = 1'b1;
      @(posedge FPGA_clk); #1;
      stop_req = 1'b0; enable = 1'b0;
      n = 0;
      while (busy && n < 100) begin @(posedge FPGA_clk); #1; n++; end
      chk("stop_len", n, 16 + PEN);
    end else begin
      n = 0;
      while (busy && n < 100) begin
        @(posedge FPGA_clk); #1; n++;
        if (n == 1) chk("done_pulse", done, 1'b0);
      end
      chk("nack_stop_len", n, 16 + PEN);
    end
    @(negedge FPGA_clk);
    chk("stop_cond", stops, 1);
    chk("idle_out", {SCL_oe, SDA_oe, busy, done}, 4'b0000);
    mon_en = 1'b0; stretch = 1'b0;
  endtask

  initial begin
    // reset held: enable toggles must have no effect
    for (int i = 0; i < 8; i++) begin
      @(posedge FPGA_clk); #2 enable = ~enable;
      @(negedge FPGA_clk);
      chk("rst_hold", {SCL_oe, SDA_oe, busy, done, acked}, 5'b0);
    end
    enable = 1'b0;
    @(posedge FPGA_clk); #2 rst = 1'b0;
    repeat (3) @(posedge FPGA_clk);
    #2;

    run_xfer(7'b0001000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer(7'b1010101, 1'b1, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of bit 4
    I2C_addr = 7'h5A; rw = 1'b0; enable = 1'b1;
    @(posedge FPGA_clk); #2 enable = 1'b0;
    repeat (2 * D + 16 * D + 2 * D) @(posedge FPGA_clk);
    #1 chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst", {SCL_oe, SDA_oe, busy, done, acked}, 5'b0);
    @(posedge FPGA_clk); #2 rst = 1'b0;
    @(posedge FPGA_clk); #2;
    run_xfer(7'h5A, 1'b0, 1'b1, 1'b0, 1'b0);

    run_xfer(7'h33, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++)
      run_xfer(7'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
